alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Pipeline stage directly upstream of the execute ALU. Accepts one decoded RV32I instruction per cycle from the decode stage over a valid/ready handshake. Selects the ALU operands X/Y and the 4-bit ALU operation code for OP, OP-IMM, LUI, AUIPC and BRANCH instructions. Presents them from registers to the ALU and the writeback/branch logic through a 2-entry skid buffer, so that IN_READY is a registered signal.

## Interface
Parameters: none (XLEN fixed at 32).
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- FLUSH  in  1  synchronous kill of all buffered entries (branch redirect)
- IN_VALID  in  1  upstream entry valid
- IN_READY  out  1  stage can accept an entry this cycle
- INSTR  in  32  raw instruction word
- PC  in  32  instruction address
- RS1_DATA, RS2_DATA  in  32 each  register-file read data
- OUT_VALID  out  1  X/Y/OP entry valid
- OUT_READY  in  1  downstream consumes the entry this cycle
- X, Y  out  32 each  ALU operands
- OP  out  4  ALU operation code, 0..9 only
- RD  out  5  destination register
- WRITE_EN  out  1  result is written back
- IS_BRANCH  out  1  entry is a conditional branch
- BR_FUNCT3  out  3  branch condition (INSTR[14:12])
- PC_OUT  out  32  PC of the entry
- ILLEGAL  out  1  unsupported encoding

## Operation
ALU codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9. This block never emits codes 10–15.

Decode rules:
- **OP (0110011):** X=RS1_DATA, Y=RS2_DATA. The code comes from funct3/funct7.
  - funct7 must be 0000000, except SUB and SRA, which use 0100000.
  - Any other funct7 → illegal.
- **OP-IMM (0010011):** X=RS1_DATA, Y=sign-extended I-immediate. There is no SUB.
  - SLLI/SRLI/SRAI: Y={27'b0, INSTR[24:20]}.
  - SRAI is selected by INSTR[30].
  - Shift funct7 other than 0000000/0100000 (SLLI: 0000000 only) → illegal.
- **LUI (0110111):** X=0, Y={INSTR[31:12],12'b0}, OP=ADD.
- **AUIPC (0010111):** X=PC, Y={INSTR[31:12],12'b0}, OP=ADD.
- **BRANCH (1100011):** X=RS1_DATA, Y=RS2_DATA, IS_BRANCH=1, WRITE_EN=0.
  - BEQ/BNE → SUB. The consumer uses isEqual.
  - BLT/BGE → SLT.
  - BLTU/BGEU → SLTU.
  - funct3 010/011 → illegal.
- **WRITE_EN rule:** WRITE_EN=1 for OP/OP-IMM/LUI/AUIPC with RD≠0. Otherwise 0.
- **Illegal or any other opcode:** ILLEGAL=1, X=Y=0, OP=ADD, WRITE_EN=0, IS_BRANCH=0. The entry still flows through the stage.

Skid buffer states:
- EMPTY: main invalid.
- ONE: main valid, skid empty.
- FULL: main and skid valid.

Outputs are always driven from the main register. IN_READY = (state≠FULL). Fire means VALID&&READY on that side.

Transitions:
- **EMPTY:** in fire → main←decoded, go to ONE.
- **ONE, in fire and out fire:** main←decoded, stay in ONE.
- **ONE, in fire only:** skid←decoded, go to FULL.
- **ONE, out fire only:** go to EMPTY.
- **FULL, out fire:** main←skid, go to ONE. No input is possible in FULL.
- **FLUSH:** next state is EMPTY regardless of in/out fire. An entry presented with FLUSH is dropped. An out fire in the FLUSH cycle still counts as consumed.

## Timing
- **Reset (RST_N low, asynchronous):** state=EMPTY, so OUT_VALID=0 and IN_READY=1. All payload outputs (X, Y, OP, RD, PC_OUT, flags) are 0.
- **Latency:** 1 cycle from in fire to OUT_VALID.
- **Throughput:** 1 entry/cycle while OUT_READY is held high.
- **Handshake rules:**
  - Output payload is stable while OUT_VALID=1 and OUT_READY=0.
  - OUT_VALID never drops without an out fire or FLUSH.
- **Backpressure:** after OUT_READY falls, at most one more entry is accepted (into skid). IN_READY goes low on the following cycle.
- **Decode path:** combinational from INSTR/RS*_DATA to the register inputs only. No input-to-output combinational path, including IN_READY.

## Structure
- **Shared package `rv32_pkg`:**
  - ALU code constants ALU_ADD..ALU_SLTU, also used by the ALU.
  - Opcode constants OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_BRANCH.
  - The issue-entry struct/field widths.
- **Sub-module `alu_op_decode`:** purely combinational. Maps INSTR/PC/RS1_DATA/RS2_DATA to the entry fields.
- **`alu_issue_stage`:** holds the state machine and the two entry registers.

## Test plan
- **ADDI x5,x1,-1:** INSTR=0xFFF08293, RS1_DATA=7, OUT_READY=1 → next cycle OUT_VALID=1, X=7, Y=0xFFFFFFFF, OP=0, RD=5, WRITE_EN=1.
- **SRAI x3,x2,4:** INSTR=0x40415193 → OP=7, Y=4.
- **LUI x1,0x12345:** INSTR=0x123450B7 → X=0, Y=0x12345000.
- **LUI x0 / illegal:** LUI with rd=x0 → WRITE_EN=0. OP-class funct7=0000001 → ILLEGAL=1, OP=0, WRITE_EN=0.
- **Backpressure:** 4 back-to-back entries A–D, OUT_READY=0 from cycle 2.
  - A is held on the outputs, B is in skid, IN_READY=0.
  - Release OUT_READY → A, B, C, D emerge in order, none lost or duplicated.
- **FLUSH while FULL:** next cycle OUT_VALID=0, IN_READY=1.
- **Reset mid-operation:** assert RST_N low while FULL → all outputs 0 immediately.
- **BLTU:** branch with funct3=110 → IS_BRANCH=1, OP=9, WRITE_EN=0, BR_FUNCT3=6.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: ALU operation codes, base opcodes and the issue-entry payload
// handed from the issue stage to the execute ALU and branch logic.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] x;
        logic [XLEN-1:0] y;
        logic [XLEN-1:0] pc;
        logic [3:0]      op;
        logic [4:0]      rd;
        logic            write_en;
        logic            is_branch;
        logic [2:0]      br_funct3;
        logic            illegal;
    } issue_entry_t;

    // funct7-independent ALU code for an OP / OP-IMM funct3.
    function automatic logic [3:0] funct3_alu_op(input logic [2:0] funct3);
        logic [3:0] code;
        case (funct3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational operand/opcode selection for OP, OP-IMM, LUI, AUIPC and BRANCH.
// Anything else, or a bad funct field, yields a zeroed ILLEGAL entry.
module alu_op_decode
    import rv32_pkg::*;
(
    input  logic [31:0]  instr,
    input  logic [31:0]  pc,
    input  logic [31:0]  rs1_data,
    input  logic [31:0]  rs2_data,
    output issue_entry_t entry
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};

    always_comb begin
        entry     = '0;
        legal     = 1'b0;
        entry.pc  = pc;
        entry.rd  = instr[11:7];
        entry.op  = ALU_ADD;

        case (opcode)
            OPC_OP: begin
                entry.x = rs1_data;
                entry.y = rs2_data;
                if (funct7 == F7_BASE) begin
                    legal    = 1'b1;
                    entry.op = funct3_alu_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    legal    = 1'b1;
                    entry.op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    legal    = 1'b1;
                    entry.op = ALU_SRA;
                end
            end
            OPC_OPIMM: begin
                entry.x  = rs1_data;
                entry.y  = imm_i;
                entry.op = funct3_alu_op(funct3);
                legal    = 1'b1;
                if (funct3 == 3'b001) begin
                    entry.y = shamt;
                    legal   = (funct7 == F7_BASE);
                end else if (funct3 == 3'b101) begin
                    entry.y = shamt;
                    legal   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    if (instr[30]) begin
                        entry.op = ALU_SRA;
                    end
                end
            end
            OPC_LUI: begin
                legal   = 1'b1;
                entry.y = imm_u;
            end
            OPC_AUIPC: begin
                legal   = 1'b1;
                entry.x = pc;
                entry.y = imm_u;
            end
            OPC_BRANCH: begin
                entry.x         = rs1_data;
                entry.y         = rs2_data;
                entry.is_branch = 1'b1;
                entry.br_funct3 = funct3;
                // Equality branches reuse SUB; the consumer tests for a zero result.
                case (funct3[2:1])
                    2'b00: begin
                        legal    = 1'b1;
                        entry.op = ALU_SUB;
                    end
                    2'b10: begin
                        legal    = 1'b1;
                        entry.op = ALU_SLT;
                    end
                    2'b11: begin
                        legal    = 1'b1;
                        entry.op = ALU_SLTU;
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            entry.x         = '0;
            entry.y         = '0;
            entry.op        = ALU_ADD;
            entry.rd        = '0;
            entry.is_branch = 1'b0;
            entry.br_funct3 = '0;
            entry.illegal   = 1'b1;
        end

        entry.write_en = legal && !entry.is_branch && (entry.rd != 5'd0);
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes one instruction per cycle into a 2-entry skid buffer so that
// in_ready and every output come straight from registers.
module alu_issue_stage
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [3:0]  op,
    output logic [4:0]  rd,
    output logic        write_en,
    output logic        is_branch,
    output logic [2:0]  br_funct3,
    output logic [31:0] pc_out,
    output logic        illegal
);

    // Bit 0 doubles as out_valid and bit 1 as "skid occupied", so both handshake outputs
    // are plain register bits.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b11
    } state_e;

    state_e       state_q;
    issue_entry_t main_q;
    issue_entry_t skid_q;
    issue_entry_t decoded;
    logic         in_fire;
    logic         out_fire;

    alu_op_decode u_decode (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .entry    (decoded)
    );

    assign out_valid = state_q[0];
    assign in_ready  = ~state_q[1];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_q  <= decoded;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_q <= decoded;
                    end else if (in_fire) begin
                        skid_q  <= decoded;
                        state_q <= StFull;
                    end else if (out_fire) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        main_q  <= skid_q;
                        state_q <= StOne;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign x         = main_q.x;
    assign y         = main_q.y;
    assign op        = main_q.op;
    assign rd        = main_q.rd;
    assign write_en  = main_q.write_en;
    assign is_branch = main_q.is_branch;
    assign br_funct3 = main_q.br_funct3;
    assign pc_out    = main_q.pc;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized traffic against a
// queue-based reference of the 2-entry buffer and an instruction-level decode model.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        write_en;
    logic        is_branch;
    logic [2:0]  br_funct3;
    logic [31:0] pc_out;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] pc;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic [2:0]  f3;
        logic        ill;
    } exp_t;

    exp_t        mq[$];
    logic [31:0] popped[$];

    alu_issue_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .op        (op),
        .rd        (rd),
        .write_en  (write_en),
        .is_branch (is_branch),
        .br_funct3 (br_funct3),
        .pc_out    (pc_out),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU codes by mnemonic: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU = 0..9.
    function automatic logic [3:0] base_code(input logic [2:0] f3);
        case (f3)
            3'd0: return 4'd0;
            3'd1: return 4'd5;
            3'd2: return 4'd8;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return 4'd6;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pcv,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit ok;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '{x: 0, y: 0, pc: pcv, op: 0, rd: ins[11:7], we: 0, br: 0, f3: 0, ill: 0};
        ok = 0;
        if (ins[6:0] == 7'h33) begin
            e.x = a;
            e.y = b;
            if (f7 == 7'h00) begin
                ok = 1;
                e.op = base_code(f3);
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                ok = 1;
                e.op = 4'd1;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                ok = 1;
                e.op = 4'd7;
            end
        end else if (ins[6:0] == 7'h13) begin
            e.x = a;
            e.y = 32'($signed(ins[31:20]));
            e.op = base_code(f3);
            ok = 1;
            if (f3 == 3'd1) begin
                e.y = 32'(ins[24:20]);
                ok = (f7 == 7'h00);
            end else if (f3 == 3'd5) begin
                e.y = 32'(ins[24:20]);
                ok = (f7 == 7'h00) || (f7 == 7'h20);
                if (f7 == 7'h20) e.op = 4'd7;
            end
        end else if (ins[6:0] == 7'h37 || ins[6:0] == 7'h17) begin
            ok = 1;
            e.x = (ins[6:0] == 7'h17) ? pcv : 32'd0;
            e.y = ins & 32'hFFFFF000;
        end else if (ins[6:0] == 7'h63) begin
            e.x = a;
            e.y = b;
            e.br = 1;
            e.f3 = f3;
            if (f3 == 3'd0 || f3 == 3'd1) begin ok = 1; e.op = 4'd1; end
            if (f3 == 3'd4 || f3 == 3'd5) begin ok = 1; e.op = 4'd8; end
            if (f3 == 3'd6 || f3 == 3'd7) begin ok = 1; e.op = 4'd9; end
        end
        if (!ok) begin
            e.x = 0; e.y = 0; e.op = 0; e.br = 0; e.f3 = 0; e.ill = 1;
        end
        e.we = ok && !e.br && (e.rd != 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        check({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
        if (mq.size() > 0) begin
            e = mq[0];
            check({tag, "_x"}, x, e.x);
            check({tag, "_y"}, y, e.y);
            check({tag, "_op"}, 32'(op), 32'(e.op));
            check({tag, "_write_en"}, 32'(write_en), 32'(e.we));
            check({tag, "_is_branch"}, 32'(is_branch), 32'(e.br));
            check({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
            check({tag, "_pc_out"}, pc_out, e.pc);
            if (e.we) check({tag, "_rd"}, 32'(rd), 32'(e.rd));
            if (e.br) check({tag, "_br_funct3"}, 32'(br_funct3), 32'(e.f3));
        end
    endtask

    // One clock: present inputs, advance the reference, then compare just after the edge.
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] pcv, input logic [31:0] a, input logic [31:0] b,
                        input logic ordy, input logic fl);
        bit   fire_in;
        bit   fire_out;
        exp_t e;
        in_valid  = v;
        instr     = ins;
        pc        = pcv;
        rs1_data  = a;
        rs2_data  = b;
        out_ready = ordy;
        flush     = fl;
        fire_in   = v && (mq.size() < 2);
        fire_out  = ordy && (mq.size() > 0);
        e = model(ins, pcv, a, b);
        @(posedge clk);
        #1;
        if (fire_out) begin
            popped.push_back(mq[0].pc);
            void'(mq.pop_front());
        end
        if (fl) mq.delete();
        else if (fire_in) mq.push_back(e);
        check_outputs(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  f7;
        int k;
        r = $urandom;
        k = $urandom_range(0, 3);
        f7 = (k < 2) ? 7'h00 : (k == 2) ? 7'h20 : 7'($urandom);
        case ($urandom_range(0, 9))
            0, 1: r = {f7, r[24:7], 7'h33};
            2, 3: r = {f7, r[24:7], 7'h13};
            4:    r = {r[31:7], 7'h37};
            5:    r = {r[31:7], 7'h17};
            6, 7: r = {r[31:7], 7'h63};
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        instr = '0;
        pc = '0;
        rs1_data = '0;
        rs2_data = '0;
        #3;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_x", x, 32'd0);
        check("reset_pc_out", pc_out, 32'd0);
        #9;
        rst_n = 1'b1;

        // ADDI x5,x1,-1
        step("addi", 1, 32'hFFF08293, 32'h100, 32'd7, 32'd0, 1, 0);
        check("addi_x", x, 32'd7);
        check("addi_y", y, 32'hFFFFFFFF);
        check("addi_op", 32'(op), 32'd0);
        check("addi_rd", 32'(rd), 32'd5);
        check("addi_we", 32'(write_en), 32'd1);
        // SRAI x3,x2,4
        step("srai", 1, 32'h40415193, 32'h104, 32'h80000000, 32'd0, 1, 0);
        check("srai_op", 32'(op), 32'd7);
        check("srai_y", y, 32'd4);
        // LUI x1,0x12345
        step("lui", 1, 32'h123450B7, 32'h108, 32'h55, 32'h66, 1, 0);
        check("lui_x", x, 32'd0);
        check("lui_y", y, 32'h12345000);
        // LUI x0 does not write back
        step("lui_x0", 1, 32'h12345037, 32'h10C, 32'd1, 32'd2, 1, 0);
        check("lui_x0_we", 32'(write_en), 32'd0);
        // OP with funct7=0000001 is illegal
        step("ill", 1, 32'h022080B3, 32'h110, 32'd9, 32'd9, 1, 0);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_op", 32'(op), 32'd0);
        check("ill_we", 32'(write_en), 32'd0);
        // BLTU x1,x2,+8
        step("bltu", 1, 32'h0020E463, 32'h114, 32'd3, 32'd4, 1, 0);
        check("bltu_br", 32'(is_branch), 32'd1);
        check("bltu_op", 32'(op), 32'd9);
        check("bltu_we", 32'(write_en), 32'd0);
        check("bltu_f3", 32'(br_funct3), 32'd6);
        step("drain0", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

        // Backpressure: A..D back to back, sink stalls from the second cycle.
        popped.delete();
        step("bp_a", 1, 32'h00108093, 32'hA00, 32'd1, 32'd0, 1, 0);
        step("bp_b", 1, 32'h00210113, 32'hB00, 32'd2, 32'd0, 0, 0);
        step("bp_c0", 1, 32'h00318193, 32'hC00, 32'd3, 32'd0, 0, 0);
        check("bp_hold_pc", pc_out, 32'hA00);
        check("bp_full_ready", 32'(in_ready), 32'd0);
        step("bp_c1", 1, 32'h00318193, 32'hC00, 32'd3, 32'd0, 1, 0);
        step("bp_c2", 1, 32'h00318193, 32'hC00, 32'd3, 32'd0, 1, 0);
        step("bp_d", 1, 32'h00420213, 32'hD00, 32'd4, 32'd0, 1, 0);
        step("bp_e", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        check("bp_count", 32'(popped.size()), 32'd4);
        if (popped.size() == 4) begin
            check("bp_order0", popped[0], 32'hA00);
            check("bp_order1", popped[1], 32'hB00);
            check("bp_order2", popped[2], 32'hC00);
            check("bp_order3", popped[3], 32'hD00);
        end

        // Flush while full
        step("fl_a", 1, 32'h00108093, 32'hE00, 32'd1, 32'd0, 0, 0);
        step("fl_b", 1, 32'h00210113, 32'hE04, 32'd2, 32'd0, 0, 0);
        step("fl_go", 1, 32'h00318193, 32'hE08, 32'd3, 32'd0, 0, 1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);

        // Reset while full
        step("rs_a", 1, 32'h00108093, 32'hF00, 32'd1, 32'd0, 0, 0);
        step("rs_b", 1, 32'h0020E463, 32'hF04, 32'd2, 32'd3, 0, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_x", x, 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_op", 32'(op), 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_flags", 32'({write_en, is_branch, illegal}), 32'd0);
        check("rst_f3", 32'(br_funct3), 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), rand_instr(), $urandom & 32'hFFFFFFFC,
                 $urandom, $urandom, ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
